// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and
// the phase-length clamp that maps a zero length to the minimum phase.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int unsigned MIN_PHASE = 1;

    // A requested length of 0 still produces a one-cycle phase.
    function automatic int unsigned eff_len(input int unsigned len);
        return (len < MIN_PHASE) ? MIN_PHASE : len;
    endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request channel of the pulse train generator.
// Handshake: a request transfers at a rising edge where req_valid && req_ready;
// req_count/req_high/req_low are only meaningful in that cycle.
interface pulse_train_gen_if #(
    parameter int DW = 8,
    parameter int WW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_count;
    logic [WW-1:0] req_high;
    logic [WW-1:0] req_low;

    modport master (
        output req_valid,
        output req_count,
        output req_high,
        output req_low,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_count,
        input  req_high,
        input  req_low,
        output req_ready
    );
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; expire pulses for one
// cycle when the loaded count has run down to zero.
module phase_timer #(
    parameter int WW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [WW-1:0] len,
    output logic          expire
);
    logic [WW-1:0] cnt;
    logic          run;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= len;
            run <= 1'b1;
        end else if (run) begin
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign expire = run && (cnt == '0);
endmodule

// File: rtl/pulse_train_gen.sv
// Emits N registered pulses of programmable high/low width per accepted
// request, then a one-cycle done strobe (qualified by aborted).
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int DW = 8,
    parameter int WW = 8
) (
    input  logic               clk,
    input  logic               rst,
    pulse_train_gen_if.slave   req,
    input  logic               abort,
    output logic               pulse_out,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [DW-1:0]      pulses_sent,
    output state_t             dbg_state
);
    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] count_q;
    logic [WW-1:0] high_m1_q;
    logic [WW-1:0] low_m1_q;
    logic [DW-1:0] sent_inc;
    logic [WW-1:0] req_high_m1;
    logic [WW-1:0] req_low_m1;
    logic          accept;
    logic          inc_sent;
    logic          abort_fin;
    logic          timer_load;
    logic [WW-1:0] timer_len;
    logic          timer_expire;

    assign sent_inc    = pulses_sent + DW'(1);
    assign req_high_m1 = WW'(eff_len(32'(req.req_high)) - 1);
    assign req_low_m1  = WW'(eff_len(32'(req.req_low)) - 1);

    phase_timer #(.WW(WW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .len    (timer_len),
        .expire (timer_expire)
    );

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        inc_sent   = 1'b0;
        abort_fin  = 1'b0;
        timer_load = 1'b0;
        timer_len  = '0;
        case (state)
            ST_IDLE: begin
                if (req.req_valid) begin
                    accept = 1'b1;
                    if (req.req_count != '0) begin
                        state_nxt  = ST_HIGH;
                        timer_load = 1'b1;
                        timer_len  = req_high_m1;
                    end else begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_HIGH: begin
                // The pulse counts once its last high cycle is reached, even if aborted there.
                inc_sent = timer_expire;
                if (abort) begin
                    state_nxt = ST_FIN;
                    abort_fin = 1'b1;
                end else if (timer_expire) begin
                    if (sent_inc == count_q) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt  = ST_LOW;
                        timer_load = 1'b1;
                        timer_len  = low_m1_q;
                    end
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_nxt = ST_FIN;
                    abort_fin = 1'b1;
                end else if (timer_expire) begin
                    state_nxt  = ST_HIGH;
                    timer_load = 1'b1;
                    timer_len  = high_m1_q;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            count_q     <= '0;
            high_m1_q   <= '0;
            low_m1_q    <= '0;
            pulses_sent <= '0;
            pulse_out   <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state     <= state_nxt;
            pulse_out <= (state_nxt == ST_HIGH);
            done      <= (state_nxt == ST_FIN);
            aborted   <= abort_fin;
            if (accept) begin
                count_q     <= req.req_count;
                high_m1_q   <= req_high_m1;
                low_m1_q    <= req_low_m1;
                pulses_sent <= '0;
            end else if (inc_sent) begin
                pulses_sent <= sent_inc;
            end
        end
    end

    assign req.req_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign dbg_state     = state;
endmodule
